lsu: RTL
========

# lsu

Load/store unit sitting directly upstream of `dmem` in the core's memory stage. Accepts one memory request at a time from execute over a valid/ready handshake. Drives `dmem`'s word-addressed write and synchronous-read ports with byte enables and lane-aligned store data. Returns sign- or zero-extended load results to writeback, and flags misaligned, out-of-range and illegal accesses.

## Interface
- `DMEM_WORDS`, 16384: dmem depth in 32-bit words; valid byte addresses are 0 .. DMEM_WORDS*4-1.
- `RD_W`, 5: destination register index width.
- One clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in RD_W: load destination register.
- `wr_addr` out 32: dmem write address, word-aligned.
- `wr_data` out 32: dmem write data, lane-replicated.
- `wr_en` out 4: dmem byte-write enables.
- `rd_addr` out 32: dmem read address, word-aligned.
- `rd_data` in 32: dmem read data, valid one edge after `rd_addr`.
- `resp_valid` out 1: load result present.
- `resp_ready` in 1: writeback accepts the result.
- `resp_data` out 32: extended load result.
- `resp_rd` out RD_W: destination of the result.
- `exc_valid` out 1: one-cycle exception pulse.
- `exc_cause` out 2: exception code. 0 = load misaligned, 1 = store misaligned, 2 = access fault, 3 = illegal funct3.
- `exc_addr` out 32: faulting byte address.

## Operation
- States: IDLE, LOAD_WAIT, RESP.
- `req_ready` = (state == IDLE). A request is accepted on a rising edge where `req_valid && req_ready`.
- Legal funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Stores with 100 or 101 are illegal.
  - Any other code is illegal.
- Exception checks, in priority order:
  - illegal funct3 → cause 3;
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) → cause 0 for loads, 1 for stores;
  - addr ≥ DMEM_WORDS*4 → cause 2.
- A faulting request is accepted and consumed:
  - no dmem write, no response;
  - `exc_valid` pulses high the cycle after acceptance, with cause and address registered;
  - state stays IDLE.
- Store:
  - `wr_en` is combinational. In IDLE with `req_valid`, `req_is_store` and no fault, wr_en = 0001<<a (byte), 0011<<a (half), or 1111 (word), where a = addr[1:0]. Otherwise 0000.
  - `wr_addr` = {addr[31:2],2'b00}.
  - `wr_data` replicates the byte 4× or the half 2×.
  - Write completes at the accepting edge; state stays IDLE.
- Load:
  - `rd_addr` is driven combinationally from `req_addr` (word-aligned) in IDLE, and from the latched address otherwise.
  - On accept, latch offset, funct3 and rd; go to LOAD_WAIT.
  - In LOAD_WAIT, select the lane from `rd_data` and sign- or zero-extend it. Register the result into `resp_data`/`resp_rd`, set `resp_valid`, go to RESP.
  - RESP → IDLE on `resp_ready`. `resp_data`/`resp_rd` are held stable while `resp_valid && !resp_ready`.

## Timing
- Reset values: state IDLE, `resp_valid` 0, `resp_data` 0, `resp_rd` 0, `exc_valid` 0, `exc_cause` 0, `exc_addr` 0.
- While `rst_n`=0: `req_ready`=0 and `wr_en`=0000.
- Store: zero-cycle write at the accepting edge. Throughput is 1 per cycle.
- Load: `resp_valid` rises 2 cycles after the accepting edge. Best-case throughput is 1 load per 3 cycles. `req_ready`=0 in LOAD_WAIT and RESP.
- Reset asserted in LOAD_WAIT or RESP: return immediately to IDLE and drop the pending response; no output glitches to 1.
- `exc_valid` is never high in the same cycle as a `wr_en` from the same request.

## Structure
- `lsu_pkg` holds:
  - `funct3_e` (LB, LH, LW, LBU, LHU);
  - `exc_cause_e`;
  - `lsu_state_e`;
  - the lane/mask helper constants.
- Sub-module `lsu_align`, purely combinational:
  - store side: byte-enable and replicated-data generation;
  - load side: lane extract plus sign/zero extension.
- The FSM and registers stay in `lsu`.

## Test plan
Bench preloads dmem word i with value i*4.
- SW 0x000080F0 to 0x40, then LB 0x40 and LBU 0x40 → wr_en 1111; resp_data 0xFFFFFFF0 then 0x000000F0, each 2 cycles after accept.
- SH 0x1234 to 0x46 → wr_en 1100, wr_data 0x12341234. Then LHU 0x46 → 0x00001234, and LW 0x44 → 0x12340044.
- LW 0x102 → exc_valid pulse, cause 0, exc_addr 0x102, no resp_valid. SH 0x101 → cause 1, wr_en 0000.
- SW to 0x10000 → cause 2, wr_en 0000. Store funct3 100 → cause 3.
- LW 0x100 with resp_ready held low 3 cycles → resp_data 0x100 stable, req_ready 0 throughout, IDLE the cycle after resp_ready.
- rst_n low during LOAD_WAIT → resp_valid never asserts, req_ready 1 the cycle after release. A following LW 0x8 → 0x8.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, state codes, lane masks and access-legality
//               helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store width and sign codes
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // Exception codes reported on exc_cause
  typedef enum logic [1:0] {
    EXC_LOAD_MISALIGN  = 2'd0,
    EXC_STORE_MISALIGN = 2'd1,
    EXC_ACCESS_FAULT   = 2'd2,
    EXC_ILLEGAL        = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RESP      = 2'd2
  } lsu_state_e;

  // FSM encodings used by the state register
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP      = 2'd2;

  // Byte-enable masks for lane 0, shifted up by the address offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size field of funct3 (bits [1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Unsigned variants exist only for loads
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic legal;
    case (f3)
      F3_LB, F3_LH, F3_LW: legal = 1'b1;
      F3_LBU, F3_LHU:      legal = !is_store;
      default:             legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Natural alignment check for a legal width code
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Request, dmem, response and exception signals of the LSU.
//               master = execute/writeback/dmem side, slave = LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
  parameter int RD_W = 5
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [RD_W-1:0] req_rd;

  logic [31:0]     wr_addr;
  logic [31:0]     wr_data;
  logic [3:0]      wr_en;
  logic [31:0]     rd_addr;
  logic [31:0]     rd_data;

  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [RD_W-1:0] resp_rd;

  logic            exc_valid;
  logic [1:0]      exc_cause;
  logic [31:0]     exc_addr;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output rd_data, resp_ready,
    input  req_ready, wr_addr, wr_data, wr_en, rd_addr,
    input  resp_valid, resp_data, resp_rd, exc_valid, exc_cause, exc_addr
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  rd_data, resp_ready,
    output req_ready, wr_addr, wr_data, wr_en, rd_addr,
    output resp_valid, resp_data, resp_rd, exc_valid, exc_cause, exc_addr
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic. Store side builds byte enables and
//               lane-replicated data; load side extracts the addressed lane
//               and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;

  // Store: replicate the datum across all lanes so dmem sees it at any offset
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = BE_BYTE << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = BE_HALF << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = BE_WORD;
        st_wdata = st_data;
      end
    endcase
  end

  assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

  // Load: bring the addressed lane down to bit 0; funct3[2] selects zero-extension
  always_comb begin
    ld_result = ld_rdata;
    case (ld_funct3[1:0])
      SZ_BYTE: ld_result = ld_funct3[2] ? {24'd0, ld_shifted[7:0]}
                                        : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_result = ld_funct3[2] ? {16'd0, ld_shifted[15:0]}
                                        : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit in front of dmem. One request at a time;
//               stores write at the accepting edge, loads return an extended
//               result two cycles later, faults produce a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 16384,
  parameter int RD_W       = 5
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

  logic [1:0]      state;
  logic [29:0]     ld_word;
  logic [1:0]      ld_off;
  logic [2:0]      ld_funct3;
  logic [RD_W-1:0] ld_rd;

  logic            accept;
  logic            fault;
  exc_cause_e      fault_cause;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_result;

  // Ready only in IDLE, and forced low while reset is held
  assign bus.req_ready = rst_n && (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // Classify the presented request: illegal, then misaligned, then range
  always_comb begin
    fault       = 1'b1;
    fault_cause = EXC_ILLEGAL;
    if (!funct3_legal(bus.req_is_store, bus.req_funct3)) begin
      fault_cause = EXC_ILLEGAL;
    end else if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
      fault_cause = bus.req_is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
    end else if ({1'b0, bus.req_addr} >= ADDR_LIMIT) begin
      fault_cause = EXC_ACCESS_FAULT;
    end else begin
      fault       = 1'b0;
      fault_cause = EXC_LOAD_MISALIGN;
    end
  end

  lsu_align u_align (
    .st_size   (bus.req_funct3[1:0]),
    .st_off    (bus.req_addr[1:0]),
    .st_data   (bus.req_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (ld_funct3),
    .ld_off    (ld_off),
    .ld_rdata  (bus.rd_data),
    .ld_result (ld_result)
  );

  // Store enables only for an accepted, fault-free store
  assign bus.wr_en   = (accept && bus.req_is_store && !fault) ? st_be : 4'b0000;
  assign bus.wr_addr = {bus.req_addr[31:2], 2'b00};
  assign bus.wr_data = st_wdata;

  // Read address follows the request in IDLE so data is ready in LOAD_WAIT
  assign bus.rd_addr = (state == ST_IDLE) ? {bus.req_addr[31:2], 2'b00}
                                          : {ld_word, 2'b00};

  // Load FSM: latch on accept, capture extended data, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ld_word        <= '0;
      ld_off         <= '0;
      ld_funct3      <= '0;
      ld_rd          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_rd    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !bus.req_is_store && !fault) begin
            ld_word   <= bus.req_addr[31:2];
            ld_off    <= bus.req_addr[1:0];
            ld_funct3 <= bus.req_funct3;
            ld_rd     <= bus.req_rd;
            state     <= ST_LOAD_WAIT;
          end
        end
        ST_LOAD_WAIT: begin
          bus.resp_data  <= ld_result;
          bus.resp_rd    <= ld_rd;
          bus.resp_valid <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Exception pulse one cycle after a faulting request is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.exc_valid <= 1'b0;
      bus.exc_cause <= '0;
      bus.exc_addr  <= '0;
    end else begin
      bus.exc_valid <= accept && fault;
      if (accept && fault) begin
        bus.exc_cause <= fault_cause;
        bus.exc_addr  <= bus.req_addr;
      end
    end
  end

endmodule
`default_nettype wire
